// File: rtl/ttl_phase_decoder.sv
// ----------------------------------------------------------------------------
// ttl_phase_decoder
//
// Purpose:
//   Phase register with load/step control driving a one-hot decoder, in the
//   spirit of a counter feeding an LS-series 3-to-8 decoder. The phase runs
//   0..LAST and wraps back to 0. The decoder output is gated by a registered
//   enable and can be made active-low.
//
// Parameters:
//   SEL_W      phase/select width; out has 2**SEL_W bits
//   LAST       highest phase value before wrapping to 0 (1..2**SEL_W-1)
//   ACTIVE_LOW 1 inverts every bit of out
//
// Ports:
//   clk      in   rising-edge clock for all state
//   rst      in   synchronous, active-high reset
//   en       in   output enable (registered before it gates out)
//   load     in   load sel into the phase register (wins over step)
//   sel      in   phase value to load; values above LAST are rejected
//   step     in   advance the phase by one (wrapping LAST -> 0)
//   skip     in   only with TTL_PHASE_SKIP_EN: with step, advance by two
//   out      out  one-hot decode of phase, gated by the registered enable
//   phase    out  current phase register
//   wrap     out  one-cycle pulse after a step carried the phase through 0
//   bad_sel  out  one-cycle pulse after a load with sel > LAST was rejected
//
// Configuration:
//   `define TTL_PHASE_SKIP_EN adds the skip input (double-step).
// ----------------------------------------------------------------------------
module ttl_phase_decoder #(
    parameter int SEL_W      = 3,
    parameter int LAST       = 2**SEL_W - 1,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 load,
    input  logic [SEL_W-1:0]     sel,
    input  logic                 step,
`ifdef TTL_PHASE_SKIP_EN
    input  logic                 skip,
`endif
    output logic [2**SEL_W-1:0]  out,
    output logic [SEL_W-1:0]     phase,
    output logic                 wrap,
    output logic                 bad_sel
);

    localparam int N = 2**SEL_W;

    // One extra bit so phase + 2 and the LAST comparison never overflow.
    localparam logic [SEL_W:0] LAST_X = (SEL_W+1)'(LAST);

    logic               en_r;
    logic [SEL_W:0]     sel_x;
    logic [SEL_W:0]     adv;
    logic [SEL_W:0]     sum;
    logic [SEL_W-1:0]   step_next;
    logic               step_wrap;
    logic [N-1:0]       dec;

    assign sel_x = {1'b0, sel};

    // Next phase for a step. Any sum past LAST means the advance passed
    // through or landed on 0, which is exactly when wrap must pulse.
    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and a latch can never be inferred.
    always_comb begin
        adv = (SEL_W+1)'(1);
`ifdef TTL_PHASE_SKIP_EN
        if (skip) adv = (SEL_W+1)'(2);
`endif
        sum       = {1'b0, phase} + adv;
        step_next = sum[SEL_W-1:0];
        step_wrap = 1'b0;
        if (sum > LAST_X) begin
            step_next = SEL_W'(sum - LAST_X - (SEL_W+1)'(1));
            step_wrap = 1'b1;
        end
    end

    // Priority rst > load > step. wrap and bad_sel default low each edge so
    // they can only ever be single-cycle pulses.
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase   <= '0;
            en_r    <= 1'b0;
            wrap    <= 1'b0;
            bad_sel <= 1'b0;
        end else begin
            en_r    <= en;
            wrap    <= 1'b0;
            bad_sel <= 1'b0;
            if (load) begin
                // A rejected load holds the phase and swallows any step.
                if (sel_x > LAST_X) bad_sel <= 1'b1;
                else                phase   <= sel;
            end else if (step) begin
                phase <= step_next;
                wrap  <= step_wrap;
            end
        end
    end

    // Decode depends only on phase and en_r, so out has no path from any
    // input. phase never exceeds LAST, so bits above LAST stay inactive.
    always_comb begin
        dec = '0;
        if (en_r) dec[phase] = 1'b1;
        out = (ACTIVE_LOW != 0) ? ~dec : dec;
    end

endmodule

// File: tb/tb_ttl_phase_decoder.sv
// ----------------------------------------------------------------------------
// tb_ttl_phase_decoder
//
// Purpose:
//   Self-checking bench for ttl_phase_decoder. Three instances share one set
//   of stimulus inputs:
//     dut0  defaults (SEL_W=3, LAST=7, ACTIVE_LOW=0), driven from a vector table
//     dut1  LAST=5, exercised by hand-written sequences (rejected loads, wrap,
//           and the double-step when TTL_PHASE_SKIP_EN is defined)
//     dut2  ACTIVE_LOW=1, exercised by a hand-written sequence
//   Inputs change #1 after a rising edge; outputs are sampled #1 after the
//   next rising edge.
// ----------------------------------------------------------------------------
module tb_ttl_phase_decoder;

    logic       clk = 1'b0;
    logic       rst, en, load, step, skip;
    logic [2:0] sel;

    logic [7:0] out0, out1, out2;
    logic [2:0] phase0, phase1, phase2;
    logic       wrap0, wrap1, wrap2;
    logic       bad0, bad1, bad2;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ttl_phase_decoder dut0 (
        .clk(clk), .rst(rst), .en(en), .load(load), .sel(sel), .step(step),
`ifdef TTL_PHASE_SKIP_EN
        .skip(skip),
`endif
        .out(out0), .phase(phase0), .wrap(wrap0), .bad_sel(bad0)
    );

    ttl_phase_decoder #(.LAST(5)) dut1 (
        .clk(clk), .rst(rst), .en(en), .load(load), .sel(sel), .step(step),
`ifdef TTL_PHASE_SKIP_EN
        .skip(skip),
`endif
        .out(out1), .phase(phase1), .wrap(wrap1), .bad_sel(bad1)
    );

    ttl_phase_decoder #(.ACTIVE_LOW(1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .load(load), .sel(sel), .step(step),
`ifdef TTL_PHASE_SKIP_EN
        .skip(skip),
`endif
        .out(out2), .phase(phase2), .wrap(wrap2), .bad_sel(bad2)
    );

    typedef struct packed {
        logic       rst;
        logic       en;
        logic       load;
        logic [2:0] sel;
        logic       step;
        logic [2:0] ph;   // expected phase after the edge
        logic [7:0] o;    // expected out after the edge
        logic       w;    // expected wrap after the edge
        logic       b;    // expected bad_sel after the edge
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic drive(input logic r, input logic e, input logic l,
                         input logic [2:0] s, input logic st, input logic sk);
        rst = r; en = e; load = l; sel = s; step = st; skip = sk;
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0);

        // ---------------- dut0: table-driven vectors ----------------
        //            rst en ld sel   st   phase out     wr bad
        vecs.push_back('{1'b1,1'b0,1'b0,3'd0,1'b0, 3'd0,8'h00,1'b0,1'b0}); // reset
        // enable + step held 9 cycles: 1..7,0,1 with wrap after 7->0
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd1,8'h02,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd2,8'h04,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd3,8'h08,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd4,8'h10,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd5,8'h20,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd6,8'h40,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd7,8'h80,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd0,8'h01,1'b1,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd1,8'h02,1'b0,1'b0});
        // idle holds
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b0, 3'd1,8'h02,1'b0,1'b0});
        // load 7, then load 3 + step together: load wins, no wrap
        vecs.push_back('{1'b0,1'b1,1'b1,3'd7,1'b0, 3'd7,8'h80,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b1,3'd3,1'b1, 3'd3,8'h08,1'b0,1'b0});
        // load of 0 does not wrap
        vecs.push_back('{1'b0,1'b1,1'b1,3'd0,1'b0, 3'd0,8'h01,1'b0,1'b0});
        // reset, then en=0 step x3: phase advances, out stays 0
        vecs.push_back('{1'b1,1'b1,1'b1,3'd5,1'b1, 3'd0,8'h00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,3'd0,1'b1, 3'd1,8'h00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,3'd0,1'b1, 3'd2,8'h00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,3'd0,1'b1, 3'd3,8'h00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b0, 3'd3,8'h08,1'b0,1'b0});
        // load 7, then reset while stepping through LAST: no wrap
        vecs.push_back('{1'b0,1'b1,1'b1,3'd7,1'b0, 3'd7,8'h80,1'b0,1'b0});
        vecs.push_back('{1'b1,1'b1,1'b0,3'd0,1'b1, 3'd0,8'h00,1'b0,1'b0});
        vecs.push_back('{1'b0,1'b0,1'b0,3'd0,1'b0, 3'd0,8'h00,1'b0,1'b0});
        // first step after reset goes to 1
        vecs.push_back('{1'b0,1'b1,1'b0,3'd0,1'b1, 3'd1,8'h02,1'b0,1'b0});

        #1;
        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].load, vecs[i].sel,
                  vecs[i].step, 1'b0);
            cycle();
            check($sformatf("v%0d phase", i), 32'(phase0), 32'(vecs[i].ph));
            check($sformatf("v%0d out", i),   32'(out0),   32'(vecs[i].o));
            check($sformatf("v%0d wrap", i),  32'(wrap0),  32'(vecs[i].w));
            check($sformatf("v%0d bad_sel", i), 32'(bad0), 32'(vecs[i].b));
        end

        // ---------------- dut1: LAST = 5 ----------------
        drive(1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0); cycle();
        check("l5 rst phase", 32'(phase1), 32'd0);
        drive(1'b0, 1'b1, 1'b1, 3'd2, 1'b0, 1'b0); cycle();
        check("l5 load2 phase", 32'(phase1), 32'd2);
        check("l5 load2 out", 32'(out1), 32'h04);
        // rejected load: phase holds, bad_sel one cycle
        drive(1'b0, 1'b1, 1'b1, 3'd6, 1'b1, 1'b0); cycle();
        check("l5 load6 phase", 32'(phase1), 32'd2);
        check("l5 load6 bad", 32'(bad1), 32'd1);
        check("l5 load6 wrap", 32'(wrap1), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0); cycle();
        check("l5 bad clears", 32'(bad1), 32'd0);
        check("l5 hold phase", 32'(phase1), 32'd2);
        drive(1'b0, 1'b1, 1'b1, 3'd7, 1'b0, 1'b0); cycle();
        check("l5 load7 bad", 32'(bad1), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0); cycle();
        check("l5 load5 phase", 32'(phase1), 32'd5);
        check("l5 load5 bad", 32'(bad1), 32'd0);
        check("l5 load5 out", 32'(out1), 32'h20);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0); cycle();
        check("l5 wrap phase", 32'(phase1), 32'd0);
        check("l5 wrap pulse", 32'(wrap1), 32'd1);
        check("l5 wrap out", 32'(out1), 32'h01);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0); cycle();
        check("l5 wrap clears", 32'(wrap1), 32'd0);
        // out[7:6] never active while walking the full range
        for (int i = 0; i < 7; i++) begin
            drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b0); cycle();
            check($sformatf("l5 walk%0d out_hi", i), 32'(out1[7:6]), 32'd0);
        end
        // phase after 7 steps from 0, modulo 6, is 1
        check("l5 walk phase", 32'(phase1), 32'd1);

`ifdef TTL_PHASE_SKIP_EN
        drive(1'b0, 1'b1, 1'b1, 3'd4, 1'b0, 1'b0); cycle();
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1); cycle();
        check("skip 4 phase", 32'(phase1), 32'd0);
        check("skip 4 wrap", 32'(wrap1), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0); cycle();
        check("skip load5 wrap", 32'(wrap1), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1); cycle();
        check("skip 5 phase", 32'(phase1), 32'd1);
        check("skip 5 wrap", 32'(wrap1), 32'd1);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b1, 1'b1); cycle();
        check("skip 1 phase", 32'(phase1), 32'd3);
        check("skip 1 wrap", 32'(wrap1), 32'd0);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b1); cycle();
        check("skip alone phase", 32'(phase1), 32'd3);
        check("skip alone wrap", 32'(wrap1), 32'd0);
`endif

        // ---------------- dut2: ACTIVE_LOW = 1 ----------------
        drive(1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0); cycle();
        check("al rst out", 32'(out2), 32'hFF);
        drive(1'b0, 1'b0, 1'b1, 3'd2, 1'b0, 1'b0); cycle();
        check("al load2 phase", 32'(phase2), 32'd2);
        check("al en0 out", 32'(out2), 32'hFF);
        drive(1'b0, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0); cycle();
        check("al en1 out", 32'(out2), 32'hFB);
        drive(1'b0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0); cycle();
        check("al en0 step out", 32'(out2), 32'hFF);
        check("al en0 step phase", 32'(phase2), 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/ttl_phase_decoder.md
TTL_PHASE_DECODER -- requirements
Module: ttl_phase_decoder

Interface
REQ-001 SHALL have parameter SEL_W, default 3: phase/select width; the decoder has 2**SEL_W outputs.
REQ-002 SHALL have parameter LAST, default 2**SEL_W-1: highest phase value used before wrapping to 0; legal range 1..2**SEL_W-1.
REQ-003 SHALL have parameter ACTIVE_LOW, default 0: when 1, every bit of out is inverted, matching LS-series active-low decoder outputs.
REQ-004 SHALL have one clock and a synchronous, active-high reset, listed first as the following two ports.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 en  input  1  output enable, registered before use.
REQ-008 load  input  1  load sel into the phase register.
REQ-009 sel  input  SEL_W  phase value to load.
REQ-010 step  input  1  advance the phase by one.
REQ-011 out  output  2**SEL_W  one-hot decode of the phase, gated by the registered enable.
REQ-012 phase  output  SEL_W  current phase register.
REQ-013 wrap  output  1  one-cycle pulse: phase went LAST->0 by stepping.
REQ-014 bad_sel  output  1  one-cycle pulse: a load was rejected because sel > LAST.

Function
REQ-015 Per clock edge, phase SHALL update with priority rst > load > step; with none active, phase SHALL hold.
REQ-016 For load with sel <= LAST, phase SHALL take the value sel on that edge.
REQ-017 For load with sel > LAST, phase SHALL hold and bad_sel SHALL be 1 for the following cycle only.
REQ-018 For step without load, phase SHALL become phase+1, or 0 when phase == LAST.
REQ-019 wrap SHALL be registered, and SHALL be 1 for exactly the cycle after an edge where step caused LAST->0.
REQ-020 A load of 0 SHALL NOT assert wrap.
REQ-021 When load and step are high together, load SHALL win, step SHALL be ignored, and wrap SHALL stay 0.
REQ-022 en_r SHALL be a register sampling en every edge.
REQ-023 out[i] SHALL equal en_r & (phase == i), inverted when ACTIVE_LOW = 1.
REQ-024 out SHALL be a function of registers only, with no combinational path from any input.
REQ-025 Latency: a load or step at edge k SHALL be visible on phase and out after edge k.
REQ-026 Latency: en at edge k SHALL gate out after edge k.
REQ-027 out bits for i > LAST SHALL always be inactive.
REQ-028 When en_r = 1, exactly one bit of out SHALL be active.
REQ-029 When en_r = 0, all bits of out SHALL be inactive.
REQ-030 Stepping with en_r = 0 SHALL still advance phase; the enable gates only out.

Reset
REQ-031 On an edge with rst = 1, all inputs SHALL be ignored, and phase, en_r, wrap and bad_sel SHALL be 0.
REQ-032 Out SHALL reset to all 0 (ACTIVE_LOW = 0) or all 1 (ACTIVE_LOW = 1).
REQ-033 Reset while stepping through LAST SHALL produce no wrap pulse.
REQ-034 After reset deasserts, the first step SHALL move phase to 1.

Configuration
REQ-035 Macro TTL_PHASE_SKIP_EN, when defined, SHALL add input skip (1 bit) after step.
REQ-036 With TTL_PHASE_SKIP_EN, step & skip SHALL advance phase by 2 modulo (LAST+1).
REQ-037 With TTL_PHASE_SKIP_EN, wrap SHALL pulse whenever that advance passes through or lands on 0.
REQ-038 With TTL_PHASE_SKIP_EN, skip without step SHALL have no effect.
REQ-039 Without the macro, there SHALL be no skip port and stepping SHALL always be +1.

Verification
REQ-040 Defaults: rst, then en = 1 and step held 9 cycles -> phase 1,2,..,7,0,1; out = 8'h02,04,..,80,01,02; wrap high only in the cycle after 7->0.
REQ-041 LAST = 5: load sel = 6 -> phase unchanged, bad_sel 1 cycle; then load sel = 5 and step -> phase 0, wrap 1 cycle, out[7:6] = 0 throughout.
REQ-042 load = 1, sel = 3, step = 1 with phase = 7 -> phase = 3, wrap = 0.
REQ-043 ACTIVE_LOW = 1: after rst out = 8'hFF; en = 1 with phase = 2 -> out = 8'hFB one cycle after en rises.
REQ-044 en = 0, step 3 times from 0 -> out = 0 throughout, phase = 3; en = 1 -> out = 8'h08 next cycle.
REQ-045 TTL_PHASE_SKIP_EN, LAST = 5, phase = 4, step & skip -> phase = 0, wrap = 1; repeat from phase 5 -> phase 1, wrap = 1.
